// File: rtl/command_framer.sv
// command_framer
//
// Host-side link controller for the phase/duty output engine. Everything runs
// in the command clock domain.
//   - Received UART bytes are assembled into 3-byte commands and issued to the
//     engine as a one-cycle strobe with the 24-bit word.
//   - A partial frame left idle for TIMEOUT_CYCLES is discarded and flagged,
//     so byte framing resynchronises after a glitch or a dropped byte.
//   - 24-bit engine replies are queued in a FIFO and sent back to the UART
//     transmitter as three bytes, most significant first.
//
// Ports
//   i_command_clk   clock, all logic on the rising edge
//   i_reset         synchronous active-high reset
//   i_rx_valid      strobe: i_rx_byte holds a new received byte
//   i_rx_byte       received byte
//   o_command       strobe: o_command_data is a freshly assembled command
//   o_command_data  {byte0, byte1, byte2}; held until the next command
//   i_reply         strobe: i_reply_data holds a reply word
//   i_reply_data    reply word from the engine
//   o_overflow      reply FIFO full (replies arriving now are dropped)
//   o_tx_valid      o_tx_byte is valid; held until accepted
//   o_tx_byte       byte to the UART transmitter
//   i_tx_ready      transmitter accepts when o_tx_valid is also high
//   o_frame_error   strobe: a partial frame was discarded on timeout

module command_framer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        i_command_clk,
  input  logic        i_reset,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_byte,
  output logic        o_command,
  output logic [23:0] o_command_data,
  input  logic        i_reply,
  input  logic [23:0] i_reply_data,
  output logic        o_overflow,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_byte,
  input  logic        i_tx_ready,
  output logic        o_frame_error
);

  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int TW_REQ = $clog2(TIMEOUT_CYCLES);
  localparam int TW     = (TW_REQ > 17) ? TW_REQ : 17;

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B0   = 2'd1,
    B1   = 2'd2,
    B2   = 2'd3
  } state_t;

  // Byte lane presented to the transmitter for a given serialiser state.
  function automatic logic [7:0] tx_lane(input state_t st, input logic [23:0] word);
    logic [7:0] lane;
    case (st)
      B0:      lane = word[23:16];
      B1:      lane = word[15:8];
      B2:      lane = word[7:0];
      default: lane = 8'h00;
    endcase
    return lane;
  endfunction

  // ---------------------------------------------------------------------------
  // Frame assembly and inter-byte timeout
  // ---------------------------------------------------------------------------
  logic [1:0]    byte_idx;
  logic [TW-1:0] idle_cnt;
  logic [7:0]    slot0;
  logic [7:0]    slot1;

  // The first two bytes are parked here; the third goes straight into the
  // command word together with them.
  always_ff @(posedge i_command_clk) begin
    if (i_rx_valid) begin
      if (byte_idx == 2'd0) slot0 <= i_rx_byte;
      if (byte_idx == 2'd1) slot1 <= i_rx_byte;
    end
  end

  always_ff @(posedge i_command_clk) begin
    if (i_reset) begin
      byte_idx       <= 2'd0;
      idle_cnt       <= '0;
      o_command      <= 1'b0;
      o_command_data <= 24'h0;
      o_frame_error  <= 1'b0;
    end else begin
      o_command     <= 1'b0;
      o_frame_error <= 1'b0;
      if (i_rx_valid) begin
        // A byte arriving on the expiry cycle wins over the timeout.
        idle_cnt <= '0;
        case (byte_idx)
          2'd0:    byte_idx <= 2'd1;
          2'd1:    byte_idx <= 2'd2;
          default: begin
            o_command_data <= {slot0, slot1, i_rx_byte};
            o_command      <= 1'b1;
            byte_idx       <= 2'd0;
          end
        endcase
      end else if (byte_idx == 2'd0) begin
        idle_cnt <= '0;
      end else if (idle_cnt == TO_LAST) begin
        byte_idx      <= 2'd0;
        idle_cnt      <= '0;
        o_frame_error <= 1'b1;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reply FIFO
  // ---------------------------------------------------------------------------
  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  state_t        state;
  state_t        state_next;

  // Fullness is judged on the registered count, so a push while full is
  // dropped even if the serialiser pops in the same cycle.
  assign push       = i_reply && (count != FULL);
  assign pop        = (state == IDLE) && (count != '0);
  assign o_overflow = (count == FULL);

  always_ff @(posedge i_command_clk) begin
    if (push) mem[wr_ptr] <= i_reply_data;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge i_command_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Reply serialiser
  // ---------------------------------------------------------------------------
  logic [23:0] reply_word;

  always_ff @(posedge i_command_clk) begin
    if (pop) reply_word <= mem[rd_ptr];
  end

  always_ff @(posedge i_command_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    o_tx_valid = 1'b0;
    o_tx_byte  = tx_lane(state, reply_word);
    case (state)
      IDLE: begin
        if (count != '0) state_next = B0;
      end
      B0: begin
        o_tx_valid = 1'b1;
        if (i_tx_ready) state_next = B1;
      end
      B1: begin
        o_tx_valid = 1'b1;
        if (i_tx_ready) state_next = B2;
      end
      B2: begin
        o_tx_valid = 1'b1;
        if (i_tx_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_command_framer.sv
`timescale 1ns/1ps
module tb_command_framer;

  localparam int FIFO_DEPTH     = 4;
  localparam int TIMEOUT_CYCLES = 16;

  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        command;
  logic [23:0] command_data;
  logic        reply;
  logic [23:0] reply_data;
  logic        overflow;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_ready;
  logic        frame_error;

  command_framer #(
    .FIFO_DEPTH    (FIFO_DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .i_command_clk (clk),
    .i_reset       (rst),
    .i_rx_valid    (rx_valid),
    .i_rx_byte     (rx_byte),
    .o_command     (command),
    .o_command_data(command_data),
    .i_reply       (reply),
    .i_reply_data  (reply_data),
    .o_overflow    (overflow),
    .o_tx_valid    (tx_valid),
    .o_tx_byte     (tx_byte),
    .i_tx_ready    (tx_ready),
    .o_frame_error (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after the rising edge that samples a stimulus, cyc holds
  // the number of that edge; outputs registered on it are seen with that cyc.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] data;
    int          at;
  } cmd_exp_t;

  cmd_exp_t   cmd_q[$];
  int         ferr_q[$];
  logic [7:0] tx_q[$];
  cmd_exp_t   mon_cmd;
  int         mon_ferr;
  logic [7:0] mon_tx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops and compares every output event the DUT presents.
  always @(negedge clk) begin
    if (!rst) begin
      if (command) begin
        if (cmd_q.size() == 0) check("cmd_unexpected", {31'b0, command}, 32'd0);
        else begin
          mon_cmd = cmd_q.pop_front();
          check("cmd_data", {8'b0, command_data}, {8'b0, mon_cmd.data});
          check("cmd_cycle", cyc, mon_cmd.at);
        end
      end
      if (frame_error) begin
        if (ferr_q.size() == 0) check("ferr_unexpected", {31'b0, frame_error}, 32'd0);
        else begin
          mon_ferr = ferr_q.pop_front();
          check("ferr_cycle", cyc, mon_ferr);
        end
      end
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) check("tx_unexpected", {24'b0, tx_byte}, 32'hFFFF_FFFF);
        else begin
          mon_tx = tx_q.pop_front();
          check("tx_byte", {24'b0, tx_byte}, {24'b0, mon_tx});
        end
      end
    end
  end

  // All drive tasks start and end at 1ns after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_reply(input logic [23:0] w);
    reply      = 1'b1;
    reply_data = w;
    @(posedge clk);
    #1;
    reply = 1'b0;
  endtask

  task automatic expect_cmd(input logic [23:0] d, input int at);
    cmd_exp_t e;
    e.data = d;
    e.at   = at;
    cmd_q.push_back(e);
  endtask

  task automatic expect_reply_bytes(input logic [23:0] w);
    tx_q.push_back(w[23:16]);
    tx_q.push_back(w[15:8]);
    tx_q.push_back(w[7:0]);
  endtask

  int n0;
  int r0;

  initial begin
    rst        = 1'b1;
    rx_valid   = 1'b0;
    rx_byte    = 8'h00;
    reply      = 1'b0;
    reply_data = 24'h0;
    tx_ready   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_command", {31'b0, command}, 32'd0);
    check("rst_command_data", {8'b0, command_data}, 32'd0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_tx_byte", {24'b0, tx_byte}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_frame_error", {31'b0, frame_error}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Back-to-back frame: command one cycle after the third byte
    send_byte(8'h41);
    send_byte(8'h01);
    send_byte(8'h23);
    expect_cmd(24'h410123, cyc);
    idle(4);

    // Timeout: lone byte, frame discarded 16 edges later, then a clean frame
    send_byte(8'h77);
    ferr_q.push_back(cyc + TIMEOUT_CYCLES);
    idle(20);
    send_byte(8'h62);
    send_byte(8'h00);
    send_byte(8'h05);
    expect_cmd(24'h620005, cyc);
    idle(4);

    // Byte arriving exactly on the expiry edge is accepted, no error
    send_byte(8'h61);
    repeat (TIMEOUT_CYCLES - 1) @(posedge clk);
    #1;
    send_byte(8'h9C);
    send_byte(8'h3E);
    expect_cmd(24'h619C3E, cyc);
    idle(TIMEOUT_CYCLES + 4);

    // Single reply with ready high: valid from t+2, three consecutive bytes
    tx_ready = 1'b1;
    send_reply(24'h00ABCD);
    r0 = cyc;
    expect_reply_bytes(24'h00ABCD);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("tx_valid_seq", {31'b0, tx_valid}, (i >= 1 && i <= 3) ? 32'd1 : 32'd0);
      if (i == 1) check("tx_first_cycle", cyc, r0 + 1);
    end
    @(posedge clk);
    #1;
    idle(2);

    // Stalled transmitter: five replies fill the FIFO plus shift register
    tx_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      reply      = 1'b1;
      reply_data = 24'(k);
      @(negedge clk);
      check("overflow_fill", {31'b0, overflow}, (k - 1 >= 5) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
      if (k <= 5) expect_reply_bytes(24'(k));
    end
    reply = 1'b0;
    @(negedge clk);
    check("overflow_after_drop", {31'b0, overflow}, 32'd1);
    check("tx_held_valid", {31'b0, tx_valid}, 32'd1);
    check("tx_held_byte", {24'b0, tx_byte}, 32'h00);
    @(posedge clk);
    #1;
    // Commands still flow while replies are stalled
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    expect_cmd(24'h123456, cyc);
    idle(3);
    tx_ready = 1'b1;
    idle(30);
    @(negedge clk);
    check("drain_tx_q_empty", tx_q.size(), 32'd0);
    check("drain_overflow", {31'b0, overflow}, 32'd0);
    check("drain_tx_valid", {31'b0, tx_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Reset during B1 with two replies queued
    tx_ready = 1'b0;
    send_reply(24'hA1A2A3);
    send_reply(24'hB1B2B3);
    send_reply(24'hC1C2C3);
    tx_q.push_back(8'hA1);
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    @(negedge clk);
    check("b1_valid", {31'b0, tx_valid}, 32'd1);
    check("b1_byte", {24'b0, tx_byte}, 32'hA2);
    check("b1_overflow", {31'b0, overflow}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("midrst_overflow", {31'b0, overflow}, 32'd0);
    check("midrst_command_data", {8'b0, command_data}, 32'd0);
    check("midrst_tx_byte", {24'b0, tx_byte}, 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    tx_ready = 1'b1;
    idle(20);

    @(negedge clk);
    check("final_cmd_q_empty", cmd_q.size(), 32'd0);
    check("final_ferr_q_empty", ferr_q.size(), 32'd0);
    check("final_tx_q_empty", tx_q.size(), 32'd0);
    check("final_tx_valid", {31'b0, tx_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
